// File: rtl/unsigned_seq_ctrl.sv
// unsigned_seq_ctrl: sequential unsigned ALU controller.
//   Add and subtract complete in one cycle. Multiply is a shift-add and divide is
//   a restoring division, each one bit per cycle for WIDTH cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   Start      begin an operation (sampled only when Busy=0)
//   OpCode     00 add, 01 subtract, 10 multiply, 11 divide
//   A, B       unsigned operands (dividend/minuend, divisor/subtrahend)
//   Busy       high while a multiply or divide is iterating
//   Done       one-cycle pulse, results valid
//   Answer     sum, difference, product low word or quotient
//   AnswerHi   product high word, remainder, or 0 for add/sub
//   CarryOut   add carry or subtract borrow, 0 otherwise
//   DivByZero  last completed divide had B=0
//
// Configuration macro:
//   UNSIGNED_SEQ_DIVZERO_FAST_EN  when defined, a divide by zero skips the DIV
//                                 iterations and finishes one cycle after acceptance.
module unsigned_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       OpCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Answer,
    output logic [WIDTH-1:0] AnswerHi,
    output logic             CarryOut,
    output logic             DivByZero
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q;
    logic [5:0]       cnt_q;
    // Multiply: work_hi_q = partial product, work_lo_q = multiplier shifting out.
    // Divide:   work_hi_q = partial remainder, work_lo_q = dividend/quotient.
    logic [WIDTH-1:0] work_hi_q;
    logic [WIDTH-1:0] work_lo_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_neg;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;
    logic             div_fast;
    logic             last_iter;

    always_comb begin
        // Shift-add step: conditionally add multiplicand, then shift {carry,hi,lo} right.
        mul_sum    = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], work_lo_q[WIDTH-1:1]};

        // Restoring step: bring in next dividend bit, subtract divisor if it fits.
        // When it fits the difference is below B, so WIDTH bits hold it exactly;
        // with B=0 it always fits and the remainder ends up equal to A.
        div_shift   = {work_hi_q, work_lo_q[WIDTH-1]};
        div_neg     = div_shift < {1'b0, b_q};
        div_rem_nxt = div_neg ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - b_q);
        div_quo_nxt = {work_lo_q[WIDTH-2:0], ~div_neg};

        add_sum    = {1'b0, A} + {1'b0, B};
        sub_diff   = A - B;
        sub_borrow = A < B;

`ifdef UNSIGNED_SEQ_DIVZERO_FAST_EN
        div_fast = (B == '0);
`else
        div_fast = 1'b0;
`endif

        last_iter = (cnt_q == 6'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            b_q       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Answer    <= '0;
            AnswerHi  <= '0;
            CarryOut  <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (Start) begin
                        cnt_q <= '0;
                        b_q   <= B;
                        unique case (OpCode)
                            2'b00: begin
                                Answer    <= add_sum[WIDTH-1:0];
                                AnswerHi  <= '0;
                                CarryOut  <= add_sum[WIDTH];
                                DivByZero <= 1'b0;
                                state_q   <= StDone;
                                Busy      <= 1'b0;
                                Done      <= 1'b1;
                            end
                            2'b01: begin
                                Answer    <= sub_diff;
                                AnswerHi  <= '0;
                                CarryOut  <= sub_borrow;
                                DivByZero <= 1'b0;
                                state_q   <= StDone;
                                Busy      <= 1'b0;
                                Done      <= 1'b1;
                            end
                            2'b10: begin
                                work_hi_q <= '0;
                                work_lo_q <= A;
                                state_q   <= StMul;
                                Busy      <= 1'b1;
                                Done      <= 1'b0;
                            end
                            2'b11: begin
                                if (div_fast) begin
                                    Answer    <= '1;
                                    AnswerHi  <= A;
                                    CarryOut  <= 1'b0;
                                    DivByZero <= 1'b1;
                                    state_q   <= StDone;
                                    Busy      <= 1'b0;
                                    Done      <= 1'b1;
                                end else begin
                                    work_hi_q <= '0;
                                    work_lo_q <= A;
                                    state_q   <= StDiv;
                                    Busy      <= 1'b1;
                                    Done      <= 1'b0;
                                end
                            end
                        endcase
                    end else begin
                        state_q <= StIdle;
                        Busy    <= 1'b0;
                        Done    <= 1'b0;
                    end
                end
                StMul: begin
                    work_hi_q <= mul_hi_nxt;
                    work_lo_q <= mul_lo_nxt;
                    cnt_q     <= cnt_q + 6'd1;
                    if (last_iter) begin
                        Answer    <= mul_lo_nxt;
                        AnswerHi  <= mul_hi_nxt;
                        CarryOut  <= 1'b0;
                        DivByZero <= 1'b0;
                        state_q   <= StDone;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                    end
                end
                StDiv: begin
                    work_hi_q <= div_rem_nxt;
                    work_lo_q <= div_quo_nxt;
                    cnt_q     <= cnt_q + 6'd1;
                    if (last_iter) begin
                        Answer    <= div_quo_nxt;
                        AnswerHi  <= div_rem_nxt;
                        CarryOut  <= 1'b0;
                        DivByZero <= (b_q == '0);
                        state_q   <= StDone;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_seq_ctrl.sv
// Self-checking bench for unsigned_seq_ctrl: directed vector table, reset
// corner cases and randomized operations against an arithmetic reference model.
module tb_unsigned_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  OpCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Answer;
    logic [31:0] AnswerHi;
    logic        CarryOut;
    logic        DivByZero;

    int checks;
    int failures;
    logic [31:0] last_ans;

    unsigned_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .OpCode    (OpCode),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Answer    (Answer),
        .AnswerHi  (AnswerHi),
        .CarryOut  (CarryOut),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ans;
        logic [31:0] hi;
        logic        c;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on wide integers.
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] ans,
                                  output logic [31:0] hi, output logic c,
                                  output logic dz, output int lat);
        logic [63:0] w;
        hi  = '0;
        c   = 1'b0;
        dz  = 1'b0;
        lat = 33;
        case (op)
            2'b00: begin
                w   = {32'h0, a} + {32'h0, b};
                ans = w[31:0];
                c   = w[32];
                lat = 1;
            end
            2'b01: begin
                ans = a - b;
                c   = (a < b);
                lat = 1;
            end
            2'b10: begin
                w   = {32'h0, a} * {32'h0, b};
                ans = w[31:0];
                hi  = w[63:32];
            end
            default: begin
                if (b == 0) begin
                    ans = 32'hFFFFFFFF;
                    hi  = a;
                    dz  = 1'b1;
`ifdef UNSIGNED_SEQ_DIVZERO_FAST_EN
                    lat = 1;
`endif
                end else begin
                    ans = a / b;
                    hi  = a % b;
                end
            end
        endcase
    endfunction

    // Called at posedge+1 with Start low (or in a DONE cycle); returns in the Done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] e_ans;
        logic [31:0] e_hi;
        logic        e_c;
        logic        e_dz;
        int          e_lat;
        int          lat;
        int          busy_cnt;
        model(op, a, b, e_ans, e_hi, e_c, e_dz, e_lat);
        OpCode = op;
        A      = a;
        B      = b;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        // Scramble inputs to show the operands were captured.
        A      = $urandom;
        B      = $urandom;
        OpCode = 2'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (Done !== 1'b1 && lat <= 40) begin
            if (Busy === 1'b1) begin
                busy_cnt++;
                Start = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            Start = 1'b0;
            lat++;
        end
        Start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(e_lat - 1));
        check({tag, " busy_in_done"}, 64'(Busy), 64'h0);
        check({tag, " answer"}, 64'(Answer), 64'(e_ans));
        check({tag, " answer_hi"}, 64'(AnswerHi), 64'(e_hi));
        check({tag, " carry"}, 64'(CarryOut), 64'(e_c));
        check({tag, " div_by_zero"}, 64'(DivByZero), 64'(e_dz));
        last_ans = e_ans;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, " idle_done"}, 64'(Done), 64'h0);
        check({tag, " idle_busy"}, 64'(Busy), 64'h0);
        check({tag, " idle_hold"}, 64'(Answer), 64'(last_ans));
    endtask

    vec_t vecs[10];

    initial begin
        int done_seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        checks   = 0;
        failures = 0;
        last_ans = '0;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 32'h0000_1234, 32'h0000_0FFF, 32'h0000_2233, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b0, 1'b1};
        vecs[7] = '{2'b01, 32'd9, 32'd9, 32'd0, 32'h0, 1'b0, 1'b0};
        vecs[8] = '{2'b10, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b0, 1'b0};
        vecs[9] = '{2'b11, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0};

        reset  = 1'b1;
        Start  = 1'b0;
        OpCode = '0;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(Busy), 64'h0);
        check("reset done", 64'(Done), 64'h0);
        check("reset answer", 64'(Answer), 64'h0);
        check("reset answer_hi", 64'(AnswerHi), 64'h0);
        check("reset carry", 64'(CarryOut), 64'h0);
        check("reset div_by_zero", 64'(DivByZero), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: constant expectations, also cross-checked against the model.
        // Even entries run back-to-back into the next one (Start during DONE).
        for (int i = 0; i < 10; i++) begin
            logic [31:0] m_ans;
            logic [31:0] m_hi;
            logic        m_c;
            logic        m_dz;
            int          m_lat;
            model(vecs[i].op, vecs[i].a, vecs[i].b, m_ans, m_hi, m_c, m_dz, m_lat);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table_answer", i), 64'(Answer), 64'(vecs[i].ans));
            check($sformatf("vec%0d table_hi", i), 64'(AnswerHi), 64'(vecs[i].hi));
            check($sformatf("vec%0d table_carry", i), 64'(CarryOut), 64'(vecs[i].c));
            check($sformatf("vec%0d table_dz", i), 64'(DivByZero), 64'(vecs[i].dz));
            if (i % 2 == 1) idle_cycle($sformatf("vec%0d", i));
        end

        // Reset at iteration 10 of a multiply, with Start also high on that edge.
        OpCode = 2'b10;
        A      = 32'hFFFFFFFF;
        B      = 32'hFFFFFFFF;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mul busy_before_reset", 64'(Busy), 64'h1);
        reset = 1'b1;
        Start = 1'b1;
        OpCode = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        Start = 1'b0;
        check("mid_reset busy", 64'(Busy), 64'h0);
        check("mid_reset done", 64'(Done), 64'h0);
        check("mid_reset answer", 64'(Answer), 64'h0);
        check("mid_reset answer_hi", 64'(AnswerHi), 64'h0);
        check("mid_reset carry", 64'(CarryOut), 64'h0);
        check("mid_reset div_by_zero", 64'(DivByZero), 64'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1 || Busy === 1'b1) done_seen++;
        end
        check("mid_reset no_done_after", 64'(done_seen), 64'h0);

        // Reset beats Start in IDLE.
        OpCode = 2'b00;
        A      = 32'd1;
        B      = 32'd1;
        Start  = 1'b1;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        Start = 1'b0;
        check("reset_vs_start done", 64'(Done), 64'h0);
        check("reset_vs_start answer", 64'(Answer), 64'h0);
        last_ans = '0;

        // Randomized operations against the model.
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = a;
                2: b = $urandom_range(0, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0 && n > 0) idle_cycle("rand");
            run_op(op, a, b, $sformatf("rand%0d", n));
        end

        idle_cycle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unsigned_seq_ctrl.md
UNSIGNED_SEQ_CTRL -- requirements
Module: unsigned_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; all values below assume 32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request to begin an operation; sampled only when Busy=0.
REQ-005 SHALL have port OpCode  input  2  operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-006 SHALL have port A  input  WIDTH  first operand (dividend / minuend), unsigned.
REQ-007 SHALL have port B  input  WIDTH  second operand (divisor / subtrahend), unsigned.
REQ-008 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port Answer  output  WIDTH  sum, difference, product low word or quotient.
REQ-011 SHALL have port AnswerHi  output  WIDTH  product high word, remainder, or 0 for add/sub.
REQ-012 SHALL have port CarryOut  output  1  add carry, subtract borrow (A<B), 0 otherwise.
REQ-013 SHALL have port DivByZero  output  1  set when a divide completed with B=0.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-015 SHALL capture A, B and OpCode into internal registers on the edge where Start=1 and Busy=0; later input changes SHALL NOT affect the operation.
REQ-016 SHALL, from IDLE or DONE with Start=1, go to DONE for OpCode 00/01, MUL for 10, DIV for 11; with Start=0, IDLE and DONE SHALL go to IDLE.
REQ-017 SHALL compute add as (A+B) mod 2^32 with CarryOut = bit 32, and subtract as (A-B) mod 2^32 with CarryOut=1 iff A<B; both SHALL reach DONE one cycle after acceptance.
REQ-018 SHALL implement multiply as a 32-iteration shift-add, one iteration per cycle in MUL, producing the exact 64-bit product {AnswerHi, Answer}.
REQ-019 SHALL implement divide as a 32-iteration restoring division, one quotient bit per cycle in DIV, giving Answer=floor(A/B) and AnswerHi=A mod B.
REQ-020 SHALL use a 6-bit iteration counter cleared on acceptance; MUL/DIV SHALL go to DONE after the 32nd iteration, so Done asserts 33 cycles after the accepting edge.
REQ-021 SHALL assert Busy in MUL and DIV only; Busy SHALL be 0 in IDLE and DONE.
REQ-022 SHALL assert Done exactly for the one cycle spent in DONE; Answer, AnswerHi, CarryOut and DivByZero SHALL update on the edge entering DONE and hold until the next entry to DONE.
REQ-023 SHALL ignore Start while Busy=1, with no queuing and no effect on the operation in progress.
REQ-024 SHALL accept Start during the DONE cycle, giving back-to-back operations with no idle gap.
REQ-025 SHALL, for divide with B=0, produce Answer=32'hFFFFFFFF, AnswerHi=A and DivByZero=1; DivByZero SHALL be 0 after every other operation.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, enter IDLE and clear Busy, Done, Answer, AnswerHi, CarryOut, DivByZero, the counter and all operand registers to 0.
REQ-027 SHALL abort any MUL/DIV in progress on reset with no Done pulse; reset SHALL take priority over Start on the same edge.

Configuration
REQ-028 SHALL honour macro UNSIGNED_SEQ_DIVZERO_FAST_EN: when defined, divide with B=0 SHALL go from acceptance directly to DONE (Done one cycle later, Busy never asserted) with REQ-025 results.
REQ-029 SHALL, without UNSIGNED_SEQ_DIVZERO_FAST_EN, run divide with B=0 through all 32 DIV iterations (Done after 33 cycles) with identical REQ-025 results.

Verification
REQ-030 SHALL cover: add A=FFFFFFFF, B=00000001 -> one cycle later Done=1, Answer=0, CarryOut=1, AnswerHi=0.
REQ-031 SHALL cover: subtract A=5, B=7 -> Answer=FFFFFFFE, CarryOut=1; then Start held in DONE with add 2+3 -> next cycle Answer=5, CarryOut=0.
REQ-032 SHALL cover: multiply FFFFFFFF x FFFFFFFF -> Busy 32 cycles, Done at cycle 33, AnswerHi=FFFFFFFE, Answer=00000001; Start pulses mid-operation ignored.
REQ-033 SHALL cover: divide 100/7 -> Answer=14, AnswerHi=2, DivByZero=0; divide 1234/0 -> Answer=FFFFFFFF, AnswerHi=1234, DivByZero=1, Done at cycle 1 with macro and cycle 33 without.
REQ-034 SHALL cover: reset asserted at iteration 10 of a multiply -> next cycle IDLE, Busy=0, all outputs 0, no Done pulse afterwards.
